// File: rtl/rx_frame_ctrl.sv
// Receive framer: parses AA-prefixed command frames and streams picture bytes into a frame buffer.
// Optional macro RX_CHECKSUM_EN appends a modulo-256 checksum byte to every command frame.
module rx_frame_ctrl #(
  parameter int PIC_BYTES   = 76800,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clock_system,
  input  logic        rstn,
  input  logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  input  logic        pic_ready,
  input  logic [7:0]  pic_data,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_arg,
  output logic        frame_done,
  output logic        err,
  output logic        busy
);

  // state      | meaning
  // IDLE       | waiting for AA sync byte or first picture byte
  // CMD_CODE   | sync seen, expecting command code
  // CMD_ARGH   | expecting argument high byte
  // CMD_ARGL   | expecting argument low byte
  // CMD_SUM    | expecting checksum byte (RX_CHECKSUM_EN only)
  // PIC_STREAM | writing picture bytes at the running index
  typedef enum logic [2:0] {
    IDLE,
    CMD_CODE,
    CMD_ARGH,
    CMD_ARGL,
`ifdef RX_CHECKSUM_EN
    CMD_SUM,
`endif
    PIC_STREAM
  } state_t;

  localparam logic [16:0] IDX_LAST = 17'(PIC_BYTES - 1);
  localparam logic [19:0] TC_LAST  = 20'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [16:0] idx;
  logic [19:0] tcnt;
  logic [7:0]  code_r;
  logic [7:0]  argh_r;
  logic        in_cmd;

`ifdef RX_CHECKSUM_EN
  logic [7:0]  argl_r;
  logic [7:0]  sum_calc;
  assign sum_calc = code_r + argh_r + argl_r;
`endif

  assign in_cmd = (state != IDLE) && (state != PIC_STREAM);

  always_ff @(posedge clock_system or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      idx        <= '0;
      tcnt       <= '0;
      code_r     <= '0;
      argh_r     <= '0;
`ifdef RX_CHECKSUM_EN
      argl_r     <= '0;
`endif
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      cmd_arg    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;

      // idx is always 0 outside PIC_STREAM, so one path serves frame start, abort and continuation
      if (pic_ready) begin
        wr_en   <= 1'b1;
        wr_addr <= idx;
        wr_data <= pic_data;
        tcnt    <= '0;
        if (in_cmd) err <= 1'b1;
        if (idx == IDX_LAST) begin
          frame_done <= 1'b1;
          idx        <= '0;
          state      <= IDLE;
          busy       <= 1'b0;
        end else begin
          idx   <= idx + 17'd1;
          state <= PIC_STREAM;
          busy  <= 1'b1;
        end
      end else if (cmd_ready && state != PIC_STREAM) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (cmd_data == 8'hAA) begin
              state <= CMD_CODE;
              busy  <= 1'b1;
            end
          end
          CMD_CODE: begin
            code_r <= cmd_data;
            state  <= CMD_ARGH;
          end
          CMD_ARGH: begin
            argh_r <= cmd_data;
            state  <= CMD_ARGL;
          end
`ifdef RX_CHECKSUM_EN
          CMD_ARGL: begin
            argl_r <= cmd_data;
            state  <= CMD_SUM;
          end
          CMD_SUM: begin
            if (cmd_data == sum_calc) begin
              cmd_valid <= 1'b1;
              cmd_code  <= code_r;
              cmd_arg   <= {argh_r, argl_r};
            end else begin
              err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          CMD_ARGL: begin
            cmd_valid <= 1'b1;
            cmd_code  <= code_r;
            cmd_arg   <= {argh_r, cmd_data};
            state     <= IDLE;
            busy      <= 1'b0;
          end
`endif
          default: ;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TC_LAST) begin
          err   <= 1'b1;
          idx   <= '0;
          tcnt  <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          tcnt <= tcnt + 20'd1;
        end
      end
    end
  end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter PIC_BYTES, default 76800, number of picture bytes per frame (1..131071).
REQ-002 Parameter TIMEOUT_CYC, default 50000, idle clock_system cycles tolerated between bytes inside a frame (1..2^20-1).
REQ-003 clock_system  in  1  single system clock; all logic rising-edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 cmd_ready  in  1  one-cycle strobe, command-rate byte valid.
REQ-006 cmd_data  in  8  command byte, valid with cmd_ready.
REQ-007 pic_ready  in  1  one-cycle strobe, picture-rate byte valid.
REQ-008 pic_data  in  8  picture byte, valid with pic_ready.
REQ-009 wr_en  out  1  one-cycle frame-buffer write strobe.
REQ-010 wr_addr  out  17  frame-buffer write address.
REQ-011 wr_data  out  8  frame-buffer write data.
REQ-012 cmd_valid  out  1  one-cycle strobe, decoded command valid.
REQ-013 cmd_code  out  8  command code, held until next cmd_valid.
REQ-014 cmd_arg  out  16  command argument {arg_hi,arg_lo}, held until next cmd_valid.
REQ-015 frame_done  out  1  one-cycle strobe, full picture written.
REQ-016 err  out  1  one-cycle strobe, frame aborted.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 States: IDLE, CMD_CODE, CMD_ARGH, CMD_ARGL, CMD_SUM, PIC_STREAM; all outputs registered.
REQ-019 IDLE: cmd_ready with cmd_data==8'hAA -> CMD_CODE; cmd_ready with any other value is discarded, state stays IDLE, no err.
REQ-020 IDLE: pic_ready -> PIC_STREAM; that byte is written at wr_addr 0 in the same transition.
REQ-021 CMD_CODE/CMD_ARGH/CMD_ARGL each capture the next cmd_ready byte into code, arg_hi, arg_lo and advance in that order.
REQ-022 cmd_valid, cmd_code, cmd_arg update one cycle after the strobe of the last frame byte; state returns to IDLE on that same edge.
REQ-023 PIC_STREAM: each pic_ready -> wr_en high next cycle with wr_data=pic_data, wr_addr=current byte index; index increments after each write.
REQ-024 On the write of index PIC_BYTES-1, frame_done pulses on the same cycle as that wr_en; index clears to 0; state -> IDLE.
REQ-025 cmd_ready in PIC_STREAM is ignored.
REQ-026 pic_ready in any CMD_* state: pending command dropped, err pulses, byte written at wr_addr 0, state -> PIC_STREAM.
REQ-027 cmd_ready and pic_ready in the same cycle: pic_ready takes priority; cmd byte discarded.
REQ-028 Timeout counter clears on every accepted strobe and on entering a non-IDLE state; it counts in every non-IDLE state.
REQ-029 Counter reaching TIMEOUT_CYC: err pulses, index clears, state -> IDLE, no cmd_valid/frame_done.
REQ-030 A strobe on the cycle the counter reaches TIMEOUT_CYC wins; no timeout occurs.
REQ-031 wr_addr holds its last value when wr_en is low.

Reset
REQ-032 rstn low asynchronously forces state IDLE, byte index 0, timeout counter 0, wr_en/cmd_valid/frame_done/err/busy 0, wr_addr/wr_data/cmd_code/cmd_arg 0.
REQ-033 Reset mid-frame discards partial data; after release the first strobe is treated as from IDLE.

Configuration
REQ-034 Macro RX_CHECKSUM_EN defined: command frame is AA,code,arg_hi,arg_lo,sum; CMD_ARGL -> CMD_SUM; cmd_valid only if sum==(code+arg_hi+arg_lo) mod 256; on mismatch err pulses and cmd_code/cmd_arg are unchanged.
REQ-035 RX_CHECKSUM_EN undefined: CMD_SUM does not exist; 4-byte frame; cmd_valid issued after arg_lo.

Verification
REQ-036 cmd bytes AA,12,34,56 (no macro) -> one cmd_valid, cmd_code=12, cmd_arg=3456, busy low after.
REQ-037 With RX_CHECKSUM_EN: AA,01,02,03,06 -> cmd_valid, cmd_arg=0203; AA,01,02,03,07 -> err pulse, no cmd_valid, outputs unchanged.
REQ-038 PIC_BYTES=4, pic bytes 10,20,30,40 -> wr_en x4 at addr 0..3 with those data; frame_done with 4th write; next byte written at addr 0.
REQ-039 TIMEOUT_CYC=100, PIC_BYTES=4: 2 pic bytes then silence -> err exactly 100 cycles after 2nd strobe, state IDLE, no frame_done.
REQ-040 AA,12 then pic_ready 55 -> err pulse, wr_en addr 0 data 55, busy high; separately rstn pulsed mid-picture -> all outputs 0 at once.
